// File: rtl/fp_to_twos_decoder_if.sv
// fp_to_twos_decoder_if
// Groups the upstream and downstream handshake signals of the FP-to-two's-complement decoder.
//   in_valid/in_ready   : upstream handshake for one FP code
//   in_sign/in_exp/in_sig : FP code fields (sign, exponent E, unsigned significand F)
//   out_valid/out_ready : downstream handshake for one linear result
//   out_data            : two's-complement result
//   busy                : decoder is mid-conversion or holding a result
// Modport "master" is the environment side (producer + consumer); "slave" is the decoder.
interface fp_to_twos_decoder_if #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [SIG_W-1:0] in_sig;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fp_to_twos_decoder.sv
// fp_to_twos_decoder
// Iteratively converts an 8-bit FP code (sign, 3-bit exponent E, 4-bit significand F,
// value = (-1)^S * F * 2^E) into a 12-bit two's-complement integer. The significand is
// shifted left one bit per clock for E cycles, then optionally negated, then held until
// the downstream consumer takes it.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fp_to_twos_decoder_if.slave (in_valid/in_ready/in_sign/in_exp/in_sig,
//         out_valid/out_ready/out_data, busy)
module fp_to_twos_decoder #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input logic                    clk,
  input logic                    rst,
  fp_to_twos_decoder_if.slave    bus
);

  // Only the default format is supported; the output must hold F shifted by the largest E plus a sign bit.
  if (EXP_W != 3 || SIG_W != 4) begin : g_bad_format
    $error("fp_to_twos_decoder: only EXP_W=3, SIG_W=4 are supported");
  end
  if (OUT_W < SIG_W + (1 << EXP_W)) begin : g_bad_width
    $error("fp_to_twos_decoder: OUT_W too narrow for the FP range");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    NEG,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic [EXP_W-1:0] count;
  logic [EXP_W-1:0] count_next;
  logic             sign_r;
  logic             sign_next;
  logic             accept;

  // The handshake only completes in IDLE, and never while reset is asserted.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = acc;

  // State and datapath registers; reset overrides any conversion or pending handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      sign_r <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      count  <= count_next;
      sign_r <= sign_next;
    end
  end

  // Next-state and datapath updates. acc is left untouched outside the conversion so
  // out_data keeps showing the last result while idle.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    sign_next  = sign_r;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_next   = {{(OUT_W-SIG_W){1'b0}}, bus.in_sig};
          count_next = bus.in_exp;
          sign_next  = bus.in_sign;
          // E = 0 needs no shifting at all.
          state_next = (bus.in_exp != '0) ? SHIFT : NEG;
        end
      end
      SHIFT: begin
        acc_next   = acc << 1;
        count_next = count - EXP_W'(1);
        if (count == EXP_W'(1)) begin
          state_next = NEG;
        end
      end
      NEG: begin
        // Negating zero wraps back to zero, so -0 decodes to 0.
        if (sign_r) begin
          acc_next = ~acc + OUT_W'(1);
        end
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fp_to_twos_decoder.md
Name: fp_to_twos_decoder

Overview:
- Iterative decoder from the team's 8-bit floating-point format to a 12-bit two's-complement integer. The format is sign, 3-bit exponent E and 4-bit significand F, with value = (-1)^S * F * 2^E.
- It is the inverse of the linear-to-floating-point encoder.
- It sits between an upstream producer of FP codes and downstream consumers of linear samples.
- Valid/ready handshakes on both sides. A multi-cycle FSM shifts one bit per clock.

Parameters:
- EXP_W, 3, exponent width. Only the default is supported.
- SIG_W, 4, significand width. Only the default is supported.
- OUT_W, 12, output width. Must satisfy OUT_W >= SIG_W + 2^EXP_W - 1 + 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream has a code on in_sign/in_exp/in_sig.
- in_ready  output  1  decoder can accept a code.
- in_sign  input  1  sign bit S; 1 = negative.
- in_exp  input  EXP_W  exponent E.
- in_sig  input  SIG_W  significand F, unsigned.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_W  two's-complement result.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE; acc, count and sign registers clear to 0.
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 0 while rst is high.
  - Reset wins over every other event, including mid-conversion and a pending handshake.
- in_ready = (state == IDLE) && !rst, decoded combinationally from state.
- out_valid = (state == DONE), registered via state.
- out_data is driven from the acc register.
- FSM states: IDLE, SHIFT, NEG, DONE.
- IDLE, on edge with in_valid && in_ready:
  - acc <= zero-extended in_sig; count <= in_exp; sign_r <= in_sign.
  - Next state is SHIFT if in_exp != 0, else NEG.
  - Without a handshake, stay in IDLE.
- SHIFT, each edge:
  - acc <= acc << 1; count <= count - 1.
  - Next state is NEG when count == 1, else stay in SHIFT.
  - Exactly E shift cycles occur.
- NEG, one edge:
  - If sign_r, acc <= ~acc + 1 (OUT_W-bit wrap); else acc unchanged.
  - Next state is DONE.
  - Negative zero (S=1, F=0) yields 0x000.
- DONE:
  - Hold acc and out_valid stable while out_ready = 0.
  - On an edge with out_ready = 1, go to IDLE.
  - acc keeps its last value, so out_data holds the last result while idle.
- Latency: out_valid rises E+2 edges after the accepting edge. Range is 2 (E=0) to 9 (E=7).
- Throughput: at most one code per E+3 cycles. No overlap: in_ready is low in SHIFT/NEG/DONE.
- in_valid while not in IDLE is ignored; the code is not captured and the upstream holds it per handshake.
- Input fields are sampled only on the accepting edge; later changes do not affect the conversion.
- Range: maximum magnitude 15*128 = 1920 (0x780), so no overflow. Minimum result -1920 (0x880).

Test Plan:
- S=0 E=0 F=0101, out_ready=1 -> out_data=0x005; out_valid 2 edges after accept, 1 cycle wide; in_ready back 1 the cycle after.
- S=0 E=7 F=1111 -> out_data=0x780 (1920), latency 9; busy high 9 cycles before the DONE handshake.
- S=1 E=3 F=1010 -> out_data=0xFB0 (-80), latency 5. S=1 E=0 F=0000 -> 0x000.
- Backpressure: S=1 E=1 F=0001 with out_ready=0 for 4 cycles in DONE -> out_data=0xFFE stable; out_valid=1; in_ready=0; an in_valid pulse with E=2 F=0011 is not captured. Raise out_ready -> IDLE next edge, then the new code decodes to 0x00C.
- Reset mid-SHIFT: accept S=0 E=6 F=1001, assert rst for 1 cycle during the 3rd SHIFT cycle -> next edge IDLE, out_valid=0, out_data=0x000, busy=0; in_ready=1 once rst is low.
- Exhaustive sweep of all 256 codes with random out_ready -> each out_data equals (-1)^S*F*2^E mod 4096 and latency equals E+2.
